// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALU codes, mux selects, controller states.
// MC_CONTROL_BNE_EN adds BNE to the set of legal opcodes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_NOR = 6'b100111;
    localparam logic [5:0] ALU_SLT = 6'b101010;
    localparam logic [5:0] ALU_SLL = 6'b000000;
    localparam logic [5:0] ALU_SRL = 6'b000010;
    localparam logic [5:0] ALU_SRA = 6'b000011;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRC_B_REG     = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11,
        StBneEx   = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [5:0] alu_control;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
`ifdef MC_CONTROL_BNE_EN
            OP_BNE: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state-to-control decode for the multicycle controller.
// Mostly Moore; FETCH handshake, branch zero and DECODE illegal detection are the exceptions.
module mc_out_decode
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_req     = 1'b1;
                ctrl.alu_src_b   = SRC_B_FOUR;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_src      = PC_SRC_ALU;
                ctrl.ir_write    = mem_ready;
                ctrl.pc_write    = mem_ready;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut while dispatching.
                ctrl.alu_src_b   = SRC_B_IMM_SH2;
                ctrl.alu_control = ALU_ADD;
                ctrl.illegal_op  = ~op_legal(opcode);
            end
            StMemAdr: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRC_B_IMM;
                ctrl.alu_control = ALU_ADD;
            end
            StMemRd: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            StRtypeEx: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRC_B_REG;
                ctrl.alu_control = funct;
            end
            StRtypeWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            StBeqEx, StBneEx: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRC_B_REG;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_src      = PC_SRC_ALUOUT;
                ctrl.pc_write    = (state == StBneEx) ? ~zero : zero;
            end
            StAddiEx: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRC_B_IMM;
                ctrl.alu_control = ALU_ADD;
            end
            StAddiWb: begin
                ctrl.reg_write = 1'b1;
            end
            StJEx: begin
                ctrl.pc_src   = PC_SRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main controller: state register, next-state logic and reset output gating.
// Define MC_CONTROL_BNE_EN to dispatch opcode 000101 to BNE_EX instead of flagging it illegal.
module mc_control
    import mips_pkg::*;
#(
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned RESET_STATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [5:0]         alu_control,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [3:0] ResetEnc = 4'(RESET_STATE);

    state_t state_q, state_d;
    ctrl_t  ctrl, ctrl_gated;

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (opcode)
                    OP_RTYPE:     state_d = StRtypeEx;
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_BEQ:       state_d = StBeqEx;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJEx;
`ifdef MC_CONTROL_BNE_EN
                    OP_BNE:       state_d = StBneEx;
`endif
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
            StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            // Writeback, branch, jump and unused encodings all return to FETCH.
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_t'(ResetEnc);
        end else begin
            state_q <= state_d;
        end
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Holding outputs low during reset keeps any write strobe from firing in that cycle.
    assign ctrl_gated = rst ? '0 : ctrl;
    assign state_dbg  = rst ? STATE_W'(ResetEnc) : STATE_W'(state_q);

    assign mem_req     = ctrl_gated.mem_req;
    assign mem_write   = ctrl_gated.mem_write;
    assign iord        = ctrl_gated.iord;
    assign ir_write    = ctrl_gated.ir_write;
    assign pc_write    = ctrl_gated.pc_write;
    assign pc_src      = ctrl_gated.pc_src;
    assign alu_src_a   = ctrl_gated.alu_src_a;
    assign alu_src_b   = ctrl_gated.alu_src_b;
    assign alu_control = ctrl_gated.alu_control;
    assign reg_write   = ctrl_gated.reg_write;
    assign reg_dst     = ctrl_gated.reg_dst;
    assign mem_to_reg  = ctrl_gated.mem_to_reg;
    assign illegal_op  = ctrl_gated.illegal_op;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle state and control vectors against hand-written tables.
module tb_mc_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_write, iord, ir_write, pc_write, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [5:0] alu_control;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state_dbg;
    logic [19:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [19:0] o;
    } row_t;

    row_t rows[$];

    always #5 clk = ~clk;

    mc_control dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    assign outs = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                   alu_control, reg_write, reg_dst, mem_to_reg, illegal_op};

    function automatic logic [19:0] pk(input logic mreq, input logic mw, input logic io,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [5:0] alu, input logic rw, input logic rd,
                                       input logic m2r, input logic ill);
        return {mreq, mw, io, irw, pcw, pcs, asa, asb, alu, rw, rd, m2r, ill};
    endfunction

    // Expected vectors, written out field by field.
    function automatic logic [19:0] v_fetch(input logic rdy);
        return pk(1, 0, 0, rdy, rdy, 2'd0, 0, 2'd1, 6'b100000, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_decode(input logic ill);
        return pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 6'b100000, 0, 0, 0, ill);
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input logic [3:0] st, input logic [19:0] o);
        row_t r;
        r.op = op; r.fn = fn; r.z = z; r.mr = mr; r.st = st; r.o = o;
        rows.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0; opcode = 6'b000000; funct = 6'b100000; zero = 0; mem_ready = 1;
        tick();
        tick();
        #1;
        checks++;
        if (state_dbg !== 4'd6) begin
            errors++;
            $display("FAIL reset_pre_state: got %0d want 6", state_dbg);
        end
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== 20'h0) begin
                errors++;
                $display("FAIL reset_outs c%0d: got %h want 00000", i, outs);
            end
            checks++;
            if (state_dbg !== 4'd0) begin
                errors++;
                $display("FAIL reset_state c%0d: got %0d want 0", i, state_dbg);
            end
            tick();
        end
        rst = 0; mem_ready = 0;
        #1;
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL reset_release_state: got %0d want 0", state_dbg);
        end
        checks++;
        if (outs !== v_fetch(1'b0)) begin
            errors++;
            $display("FAIL reset_release_outs: got %h want %h", outs, v_fetch(1'b0));
        end
        tick();
    endtask

    task automatic test_rtype_addi();
        rows.delete();
        add(6'b000000, 6'b100010, 0, 1, 4'd0, v_fetch(1));
        add(6'b000000, 6'b100010, 0, 0, 4'd1, v_decode(0));
        add(6'b000000, 6'b100010, 0, 1, 4'd6, pk(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 6'b100010, 0, 0, 0, 0));
        add(6'b000000, 6'b100010, 0, 1, 4'd7, pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 6'b000000, 1, 1, 0, 0));
        // Shift funct passes straight through.
        add(6'b000000, 6'b000011, 0, 1, 4'd0, v_fetch(1));
        add(6'b000000, 6'b000011, 0, 1, 4'd1, v_decode(0));
        add(6'b000000, 6'b000011, 0, 1, 4'd6, pk(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 6'b000011, 0, 0, 0, 0));
        add(6'b000000, 6'b000011, 0, 1, 4'd7, pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 6'b000000, 1, 1, 0, 0));
        add(6'b001000, 6'b000000, 0, 1, 4'd0, v_fetch(1));
        add(6'b001000, 6'b000000, 0, 1, 4'd1, v_decode(0));
        add(6'b001000, 6'b000000, 0, 1, 4'd9, pk(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 6'b100000, 0, 0, 0, 0));
        add(6'b001000, 6'b000000, 0, 1, 4'd10, pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 6'b000000, 1, 0, 0, 0));
        add(6'b001000, 6'b000000, 0, 0, 4'd0, v_fetch(0));
        foreach (rows[i]) begin
            opcode = rows[i].op; funct = rows[i].fn; zero = rows[i].z; mem_ready = rows[i].mr;
            #1;
            checks++;
            if (state_dbg !== rows[i].st) begin
                errors++;
                $display("FAIL rtype_addi state r%0d: got %0d want %0d", i, state_dbg, rows[i].st);
            end
            checks++;
            if (outs !== rows[i].o) begin
                errors++;
                $display("FAIL rtype_addi outs r%0d: got %h want %h", i, outs, rows[i].o);
            end
            tick();
        end
    endtask

    task automatic test_memory();
        logic [19:0] rd_v, wr_v;
        rd_v = pk(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 6'b000000, 0, 0, 0, 0);
        wr_v = pk(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 6'b000000, 0, 0, 0, 0);
        rows.delete();
        add(6'b100011, 0, 0, 1, 4'd0, v_fetch(1));
        add(6'b100011, 0, 0, 1, 4'd1, v_decode(0));
        add(6'b100011, 0, 0, 1, 4'd2, pk(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 6'b100000, 0, 0, 0, 0));
        add(6'b100011, 0, 0, 0, 4'd3, rd_v);
        add(6'b100011, 0, 0, 0, 4'd3, rd_v);
        add(6'b100011, 0, 0, 0, 4'd3, rd_v);
        add(6'b100011, 0, 0, 1, 4'd3, rd_v);
        add(6'b100011, 0, 0, 1, 4'd4, pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 6'b000000, 1, 0, 1, 0));
        // sw with one fetch wait cycle.
        add(6'b101011, 0, 0, 0, 4'd0, v_fetch(0));
        add(6'b101011, 0, 0, 1, 4'd0, v_fetch(1));
        add(6'b101011, 0, 0, 0, 4'd1, v_decode(0));
        add(6'b101011, 0, 0, 0, 4'd2, pk(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 6'b100000, 0, 0, 0, 0));
        add(6'b101011, 0, 0, 0, 4'd5, wr_v);
        add(6'b101011, 0, 0, 1, 4'd5, wr_v);
        add(6'b101011, 0, 0, 0, 4'd0, v_fetch(0));
        foreach (rows[i]) begin
            opcode = rows[i].op; funct = rows[i].fn; zero = rows[i].z; mem_ready = rows[i].mr;
            #1;
            checks++;
            if (state_dbg !== rows[i].st) begin
                errors++;
                $display("FAIL memory state r%0d: got %0d want %0d", i, state_dbg, rows[i].st);
            end
            checks++;
            if (outs !== rows[i].o) begin
                errors++;
                $display("FAIL memory outs r%0d: got %h want %h", i, outs, rows[i].o);
            end
            tick();
        end
    endtask

    task automatic test_branch_jump();
        rows.delete();
        add(6'b000100, 0, 1, 1, 4'd0, v_fetch(1));
        add(6'b000100, 0, 1, 1, 4'd1, v_decode(0));
        add(6'b000100, 0, 1, 1, 4'd8, pk(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 6'b100010, 0, 0, 0, 0));
        add(6'b000100, 0, 0, 1, 4'd0, v_fetch(1));
        add(6'b000100, 0, 0, 1, 4'd1, v_decode(0));
        add(6'b000100, 0, 0, 1, 4'd8, pk(0, 0, 0, 0, 0, 2'd1, 1, 2'd0, 6'b100010, 0, 0, 0, 0));
        add(6'b000010, 0, 0, 1, 4'd0, v_fetch(1));
        add(6'b000010, 0, 0, 1, 4'd1, v_decode(0));
        add(6'b000010, 0, 0, 1, 4'd11, pk(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 6'b000000, 0, 0, 0, 0));
        add(6'b000010, 0, 0, 0, 4'd0, v_fetch(0));
        foreach (rows[i]) begin
            opcode = rows[i].op; funct = rows[i].fn; zero = rows[i].z; mem_ready = rows[i].mr;
            #1;
            checks++;
            if (state_dbg !== rows[i].st) begin
                errors++;
                $display("FAIL branch_jump state r%0d: got %0d want %0d", i, state_dbg, rows[i].st);
            end
            checks++;
            if (outs !== rows[i].o) begin
                errors++;
                $display("FAIL branch_jump outs r%0d: got %h want %h", i, outs, rows[i].o);
            end
            tick();
        end
    endtask

    task automatic test_illegal_bne();
        rows.delete();
        add(6'b111111, 0, 0, 1, 4'd0, v_fetch(1));
        add(6'b111111, 0, 0, 1, 4'd1, v_decode(1));
        add(6'b111111, 0, 0, 1, 4'd0, v_fetch(1));
        add(6'b000101, 0, 0, 1, 4'd1, v_decode(
`ifdef MC_CONTROL_BNE_EN
            0));
        add(6'b000101, 0, 0, 1, 4'd12, pk(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 6'b100010, 0, 0, 0, 0));
        add(6'b000101, 0, 1, 1, 4'd0, v_fetch(1));
        add(6'b000101, 0, 1, 1, 4'd1, v_decode(0));
        add(6'b000101, 0, 1, 1, 4'd12, pk(0, 0, 0, 0, 0, 2'd1, 1, 2'd0, 6'b100010, 0, 0, 0, 0));
`else
            1));
`endif
        add(6'b000101, 0, 0, 0, 4'd0, v_fetch(0));
        foreach (rows[i]) begin
            opcode = rows[i].op; funct = rows[i].fn; zero = rows[i].z; mem_ready = rows[i].mr;
            #1;
            checks++;
            if (state_dbg !== rows[i].st) begin
                errors++;
                $display("FAIL illegal_bne state r%0d: got %0d want %0d", i, state_dbg, rows[i].st);
            end
            checks++;
            if (outs !== rows[i].o) begin
                errors++;
                $display("FAIL illegal_bne outs r%0d: got %h want %h", i, outs, rows[i].o);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1; opcode = '0; funct = '0; zero = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        test_reset();
        test_rtype_addi();
        test_memory();
        test_branch_jump();
        test_illegal_bne();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
